// File: rtl/cache_pkg.sv
// Shared widths, FSM state type and address-field helpers for the
// direct-mapped write-through data cache.
package cache_pkg;

  localparam int ADDR_W    = 10;
  localparam int INDEX_W   = 5;
  localparam int OFFSET_W  = 2;
  localparam int TAG_W     = ADDR_W - INDEX_W - OFFSET_W;
  localparam int WORD_W    = 32;
  localparam int BLOCK_W   = 128;
  localparam int NUM_LINES = 1 << INDEX_W;
  localparam int NUM_WORDS = 1 << OFFSET_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    WR_MEM  = 2'd2,
    WR_DONE = 2'd3
  } state_e;

  function automatic logic [TAG_W-1:0] get_tag(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [INDEX_W-1:0] get_index(input logic [ADDR_W-1:0] addr);
    return addr[OFFSET_W +: INDEX_W];
  endfunction

  function automatic logic [OFFSET_W-1:0] get_offset(input logic [ADDR_W-1:0] addr);
    return addr[OFFSET_W-1:0];
  endfunction

endpackage

// File: rtl/cache_line_array.sv
// Valid/tag/data storage for 32 cache lines: combinational lookup, full-line
// fill, single-word update, and valid bits cleared by the asynchronous reset.
module cache_line_array
  import cache_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [INDEX_W-1:0]  rd_index,
  output logic                rd_valid,
  output logic [TAG_W-1:0]    rd_tag,
  output logic [BLOCK_W-1:0]  rd_data,
  input  logic                fill_en,
  input  logic [INDEX_W-1:0]  fill_index,
  input  logic [TAG_W-1:0]    fill_tag,
  input  logic [BLOCK_W-1:0]  fill_data,
  input  logic                upd_en,
  input  logic [INDEX_W-1:0]  upd_index,
  input  logic [OFFSET_W-1:0] upd_offset,
  input  logic [WORD_W-1:0]   upd_word
);

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] valid_d;
  logic [TAG_W-1:0]     tag_mem [NUM_LINES];

  always_comb begin
    valid_d = valid_q;
    if (fill_en) valid_d[fill_index] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  // Tags and data are deliberately left unreset; the valid bit guards them.
  always_ff @(posedge clk) begin
    if (fill_en) tag_mem[fill_index] <= fill_tag;
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_mem[rd_index];

  // One word-wide lane per block word so a store touches only its own lane.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_WORDS; gi++) begin : g_lane
      logic [WORD_W-1:0] word_mem [NUM_LINES];

      always_ff @(posedge clk) begin
        if (fill_en)
          word_mem[fill_index] <= fill_data[gi*WORD_W +: WORD_W];
        else if (upd_en && (upd_offset == OFFSET_W'(gi)))
          word_mem[upd_index] <= upd_word;
      end

      assign rd_data[gi*WORD_W +: WORD_W] = word_mem[rd_index];
    end
  endgenerate

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped, write-through, no-write-allocate data cache controller:
// request FSM, hit detection and latched memory request registers.
module dcache_controller
  import cache_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               cpu_read,
  input  logic               cpu_write,
  input  logic [ADDR_W-1:0]  cpu_addr,
  input  logic [WORD_W-1:0]  cpu_wdata,
  output logic [WORD_W-1:0]  cpu_rdata,
  output logic               stall,
  output logic               mem_read,
  output logic               mem_write,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [WORD_W-1:0]  mem_wdata,
  input  logic [BLOCK_W-1:0] mem_block,
  input  logic               mem_ready
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
  logic [WORD_W-1:0]   req_wdata_q, req_wdata_d;

  logic [ADDR_W-1:0]   lookup_addr;
  logic                line_valid;
  logic [TAG_W-1:0]    line_tag;
  logic [BLOCK_W-1:0]  line_data;
  logic                hit;
  logic                fill_en;
  logic                upd_en;

  // In IDLE the CPU address is looked up; otherwise the latched request is.
  assign lookup_addr = (state_q == IDLE) ? cpu_addr : req_addr_q;
  assign hit         = line_valid && (line_tag == get_tag(lookup_addr));

  cache_line_array u_lines (
    .clk        (clk),
    .rst        (rst),
    .rd_index   (get_index(lookup_addr)),
    .rd_valid   (line_valid),
    .rd_tag     (line_tag),
    .rd_data    (line_data),
    .fill_en    (fill_en),
    .fill_index (get_index(req_addr_q)),
    .fill_tag   (get_tag(req_addr_q)),
    .fill_data  (mem_block),
    .upd_en     (upd_en),
    .upd_index  (get_index(req_addr_q)),
    .upd_offset (get_offset(req_addr_q)),
    .upd_word   (req_wdata_q)
  );

  always_comb begin
    state_d     = state_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    stall       = 1'b0;
    fill_en     = 1'b0;
    upd_en      = 1'b0;
    cpu_rdata   = '0;
    unique case (state_q)
      IDLE: begin
        if (hit) cpu_rdata = line_data[get_offset(cpu_addr)*WORD_W +: WORD_W];
        if (cpu_write) begin
          stall       = 1'b1;
          req_addr_d  = cpu_addr;
          req_wdata_d = cpu_wdata;
          state_d     = WR_MEM;
        end else if (cpu_read && !hit) begin
          stall      = 1'b1;
          req_addr_d = cpu_addr;
          state_d    = RD_MISS;
        end
      end
      RD_MISS: begin
        stall = 1'b1;
        if (mem_ready) begin
          fill_en = 1'b1;
          state_d = IDLE;
        end
      end
      WR_MEM: begin
        stall = 1'b1;
        if (mem_ready) begin
          upd_en  = hit;
          state_d = WR_DONE;
        end
      end
      WR_DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
    end
  end

  // Requests come from the registered state only, so they drop the cycle after
  // mem_ready and vanish immediately on reset.
  assign mem_read  = (state_q == RD_MISS);
  assign mem_write = (state_q == WR_MEM);
  assign mem_addr  = req_addr_q;
  assign mem_wdata = req_wdata_q;

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller with a 4-cycle word-addressable
// memory model and hand-computed expected values.
module tb_dcache_controller;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cpu_read = 1'b0;
  logic         cpu_write = 1'b0;
  logic [9:0]   cpu_addr = '0;
  logic [31:0]  cpu_wdata = '0;
  logic [31:0]  cpu_rdata;
  logic         stall;
  logic         mem_read;
  logic         mem_write;
  logic [9:0]   mem_addr;
  logic [31:0]  mem_wdata;
  logic [127:0] mem_block;
  logic         mem_ready;

  int total = 0;
  int bad   = 0;

  dcache_controller dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_read  (cpu_read),
    .cpu_write (cpu_write),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .stall     (stall),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_block (mem_block),
    .mem_ready (mem_ready)
  );

  always #5 clk = ~clk;

  // Memory model: mem_ready pulses in the cycle after the 4th request cycle.
  logic [31:0] mem [1024];
  logic [2:0]  lat_cnt = '0;
  logic        ready_r = 1'b0;
  logic [9:0]  blk_base;
  int          rd_txn = 0;
  int          wr_txn = 0;
  int          rd_req_cycles = 0;
  logic [9:0]  last_raddr = '0;
  logic [9:0]  last_waddr = '0;
  logic [31:0] last_wdata = '0;

  assign mem_ready = ready_r;
  assign blk_base  = {mem_addr[9:2], 2'b00};
  assign mem_block = {mem[blk_base + 10'd3], mem[blk_base + 10'd2],
                      mem[blk_base + 10'd1], mem[blk_base]};

  always @(posedge clk) begin
    if (mem_read) rd_req_cycles <= rd_req_cycles + 1;
    if ((mem_read || mem_write) && !ready_r) begin
      if (lat_cnt == 3'd3) begin
        ready_r <= 1'b1;
        lat_cnt <= '0;
      end else begin
        lat_cnt <= lat_cnt + 3'd1;
      end
    end else begin
      ready_r <= 1'b0;
      if (!(mem_read || mem_write)) lat_cnt <= '0;
    end
    if (ready_r && mem_read) begin
      rd_txn     <= rd_txn + 1;
      last_raddr <= mem_addr;
    end
    if (ready_r && mem_write) begin
      wr_txn        <= wr_txn + 1;
      last_waddr    <= mem_addr;
      last_wdata    <= mem_wdata;
      mem[mem_addr] <= mem_wdata;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One CPU request held until stall drops; checks stall length and load data.
  task automatic do_txn(input string tag, input logic rd, input logic wr,
                        input logic [9:0] addr, input logic [31:0] wdata,
                        input int exp_stalls, input logic [31:0] exp_rdata);
    int n;
    @(posedge clk); #1;
    cpu_read  = rd;
    cpu_write = wr;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    n = 0;
    forever begin
      @(negedge clk);
      if (!stall) break;
      n++;
      if (n > 40) break;
      @(posedge clk); #1;
    end
    check_eq({tag, "_stalls"}, 32'(n), 32'(exp_stalls));
    if (rd && !wr) check_eq({tag, "_rdata"}, cpu_rdata, exp_rdata);
    $display("txn %s rd=%0b wr=%0b addr=%h stalls=%0d rdata=%h", tag, rd, wr, addr, n, cpu_rdata);
    @(posedge clk); #1;
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    if (wr) begin
      @(negedge clk);
      check_eq({tag, "_idle_stall"}, 32'(stall), 32'd0);
      check_eq({tag, "_idle_mwr"}, 32'(mem_write), 32'd0);
    end
  endtask

  initial begin
    int rd0, wr0, rq0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 | 32'(i);
    mem[10'h010] = 32'hDEAD_BEEF;

    #3;
    check_eq("rst_stall", 32'(stall), 32'd0);
    check_eq("rst_mem_read", 32'(mem_read), 32'd0);
    check_eq("rst_mem_write", 32'(mem_write), 32'd0);
    check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
    check_eq("rst_mem_wdata", mem_wdata, 32'd0);
    check_eq("rst_cpu_rdata", cpu_rdata, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Cold read miss then block reuse.
    rd0 = rd_txn;
    do_txn("cold_rd", 1'b1, 1'b0, 10'h010, 32'h0, 6, 32'hDEAD_BEEF);
    check_eq("cold_rd_txn", 32'(rd_txn - rd0), 32'd1);
    check_eq("cold_rd_addr", 32'(last_raddr), 32'h010);
    do_txn("reuse_rd", 1'b1, 1'b0, 10'h011, 32'h0, 0, 32'hA000_0011);
    check_eq("reuse_rd_txn", 32'(rd_txn - rd0), 32'd1);

    // Write hit updates memory and the cached word.
    wr0 = wr_txn;
    do_txn("wr_hit", 1'b0, 1'b1, 10'h012, 32'h1234_5678, 6, 32'h0);
    check_eq("wr_hit_txn", 32'(wr_txn - wr0), 32'd1);
    check_eq("wr_hit_addr", 32'(last_waddr), 32'h012);
    check_eq("wr_hit_data", last_wdata, 32'h1234_5678);
    do_txn("wr_hit_rd", 1'b1, 1'b0, 10'h012, 32'h0, 0, 32'h1234_5678);

    // Write miss to a conflicting tag: memory only, line untouched.
    do_txn("wr_miss", 1'b0, 1'b1, 10'h090, 32'hCAFE_F00D, 6, 32'h0);
    check_eq("wr_miss_mem", mem[10'h090], 32'hCAFE_F00D);
    do_txn("line_kept", 1'b1, 1'b0, 10'h010, 32'h0, 0, 32'hDEAD_BEEF);

    // Conflict eviction: each read misses.
    rd0 = rd_txn;
    do_txn("evict_a", 1'b1, 1'b0, 10'h090, 32'h0, 6, 32'hCAFE_F00D);
    do_txn("evict_b", 1'b1, 1'b0, 10'h010, 32'h0, 6, 32'hDEAD_BEEF);
    do_txn("evict_c", 1'b1, 1'b0, 10'h091, 32'h0, 6, 32'hA000_0091);
    check_eq("evict_txn", 32'(rd_txn - rd0), 32'd3);

    // Reset during RD_MISS.
    @(posedge clk); #1;
    cpu_read = 1'b1;
    cpu_addr = 10'h020;
    @(negedge clk);
    check_eq("rstmid_stall0", 32'(stall), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("rstmid_mrd_before", 32'(mem_read), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("rstmid_mrd_after", 32'(mem_read), 32'd0);
    cpu_read = 1'b0;
    #1;
    check_eq("rstmid_stall", 32'(stall), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    do_txn("post_rst_a", 1'b1, 1'b0, 10'h091, 32'h0, 6, 32'hA000_0091);
    do_txn("post_rst_b", 1'b1, 1'b0, 10'h020, 32'h0, 6, 32'hA000_0020);

    // Simultaneous read and write: only the write reaches memory.
    rd0 = rd_txn;
    wr0 = wr_txn;
    rq0 = rd_req_cycles;
    do_txn("prio", 1'b1, 1'b1, 10'h030, 32'h55AA_55AA, 6, 32'h0);
    check_eq("prio_rd_txn", 32'(rd_txn - rd0), 32'd0);
    check_eq("prio_rd_cycles", 32'(rd_req_cycles - rq0), 32'd0);
    check_eq("prio_wr_txn", 32'(wr_txn - wr0), 32'd1);
    check_eq("prio_mem", mem[10'h030], 32'h55AA_55AA);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
